dsp_psk_modulator: RTL and testbench
====================================

Name: dsp_psk_modulator

Overview:
- BPSK transmitter for the PSK correlator link: it is the transmit-side counterpart of the correlator receiver.
- Serializes bytes from a valid/ready stream, MSB first. Each bit is held for SYM_LEN clocks, which matches the receiver integration period.
- Each bit modulates a 1-bit square-wave carrier from a free-running phase accumulator: bit 1 inverts the carrier, bit 0 passes it.
- Each burst starts with a preamble so the receiver loop can acquire phase before data.

Parameters:
PHASE_W, 13, phase accumulator width; carrier = acc[PHASE_W-1]
SYM_LEN, 256, clocks per symbol (>=2)
PREAMBLE_SYMS, 16, preamble symbols per burst (>=1, even)

Ports:
clk  in  1  system clock
rst_in  in  1  asynchronous reset, active-low
fcw  in  PHASE_W  carrier frequency control word, added to the accumulator every clk
data  in  8  byte to transmit
valid  in  1  data is valid
ready  out  1  block accepts data this cycle
sig  out  1  modulated BPSK bitstream (registered)
busy  out  1  high in PREAMBLE or DATA
sym_stb  out  1  one-cycle pulse on the last clock of every transmitted symbol

Behaviour:
- Clocking and reset:
  - Single clock domain; all state is on posedge clk.
  - rst_in low asynchronously clears: acc=0, state=IDLE, sym_cnt=0, bit_idx=7, pre_cnt=0, shreg=0, cur_bit=0, sig=0, busy=0, sym_stb=0.
  - ready is forced 0 while rst_in is low.
- Carrier:
  - acc <= acc + fcw every cycle in all states, modulo 2^PHASE_W.
  - The accumulator is never cleared except by reset, so carrier phase is continuous across symbols and bursts.
  - fcw changes take effect on the next add.
- Output:
  - sig <= acc[PHASE_W-1] ^ cur_bit, one cycle of latency from the accumulator.
  - cur_bit is 0 in IDLE, so sig is the bare carrier.
- FSM states: IDLE, PREAMBLE, DATA.
- IDLE:
  - ready=1, busy=0.
  - On valid&&ready: shreg<=data, sym_cnt<=0, pre_cnt<=0, cur_bit<=1, go to PREAMBLE.
- PREAMBLE:
  - Symbols alternate 1,0,1,0,... starting with 1, for PREAMBLE_SYMS symbols.
  - sym_cnt counts 0..SYM_LEN-1; sym_stb=1 when sym_cnt==SYM_LEN-1.
  - At each symbol end, cur_bit toggles and pre_cnt increments.
  - At the end of preamble symbol PREAMBLE_SYMS-1: cur_bit<=shreg[7], bit_idx<=7, go to DATA.
- DATA:
  - Each symbol transmits shreg[bit_idx].
  - At symbol end with bit_idx>0: bit_idx decrements, cur_bit<=shreg[bit_idx-1].
  - ready=1 only on the last clock of bit 0 (bit_idx==0 and sym_cnt==SYM_LEN-1).
  - If valid is high that cycle: load the new byte, cur_bit<=data[7], bit_idx<=7, stay in DATA. There is no preamble and no gap.
  - If valid is low that cycle: cur_bit<=0, go to IDLE.
- Burst length: exactly (PREAMBLE_SYMS + 8*N)*SYM_LEN clocks for N back-to-back bytes.
- Handshake:
  - data is sampled only when valid&&ready.
  - valid asserted while ready=0 is held pending; it is not lost and not sampled.
  - Changes to data while ready=0 have no effect.
- Reset mid-burst: the burst aborts immediately and the current byte is discarded. After release the block is in IDLE with ready=1 on the first clock.
- sym_cnt is $clog2(SYM_LEN) bits wide and wraps to 0 at SYM_LEN-1.

Test Plan:
- Reset check: drive rst_in=0 mid-operation -> sig=0, ready=0, busy=0, sym_stb=0 asynchronously. Release -> ready=1, busy=0 on the next cycle.
- Idle carrier: fcw=512, PHASE_W=13, no valid -> sig is a square wave with period 16 clocks (8 high, 8 low), first rising edge 9 clocks after reset release.
- Single byte: SYM_LEN=8, PREAMBLE_SYMS=4, fcw=0, send 0xA5 -> sig (carrier=0) shows symbols 1,0,1,0 then 1,0,1,0,0,1,0,1, each 8 clocks. sym_stb fires 12 times, busy is high for 96 clocks, then IDLE with sig=0.
- Back-to-back: send 0xFF then 0x00 with valid held high -> the second handshake lands on the last clock of bit 0 of 0xFF. There is no preamble between bytes, and busy is high for 160 clocks continuous.
- Underrun: send 0x81, drop valid, reassert 20 clocks after IDLE -> a new 4-symbol preamble precedes the second byte.
- Phase continuity: fcw=512 across a burst -> carrier edges (sig XOR expected bit) stay on the 8-clock grid with no phase jump at symbol or burst boundaries.

Source files
------------

// File: rtl/dsp_psk_modulator.sv
// BPSK transmitter: serializes bytes MSB first behind an alternating preamble and
// XORs each symbol onto a square-wave carrier taken from a free-running phase accumulator.
module dsp_psk_modulator #(
  parameter int PHASE_W       = 13,
  parameter int SYM_LEN       = 256,
  parameter int PREAMBLE_SYMS = 16
) (
  input  logic               clk,
  input  logic               rst_in,
  input  logic [PHASE_W-1:0] fcw,
  input  logic [7:0]         data,
  input  logic               valid,
  output logic               ready,
  output logic               sig,
  output logic               busy,
  output logic               sym_stb
);

  localparam int CNT_W = $clog2(SYM_LEN);
  localparam int PRE_W = (PREAMBLE_SYMS > 1) ? $clog2(PREAMBLE_SYMS) : 1;
  localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(SYM_LEN - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_SYMS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [PHASE_W-1:0] acc;
  logic [1:0]         state;
  logic [CNT_W-1:0]   sym_cnt;
  logic [2:0]         bit_idx;
  logic [PRE_W-1:0]   pre_cnt;
  logic [7:0]         shreg;
  logic               cur_bit;
  logic               sym_end;
  logic               accept;

  assign sym_end = (sym_cnt == SYM_LAST);

  // Ready is also open on the final clock of bit 0 so back-to-back bytes leave no gap.
  always_comb begin
    ready = 1'b0;
    if (rst_in) begin
      ready = (state == S_IDLE) ||
              ((state == S_DATA) && (bit_idx == 3'd0) && sym_end);
    end
  end

  assign accept = valid && ready;

  // Carrier and registered outputs; busy/sym_stb are delayed one clock to line up with sig.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      acc     <= '0;
      sig     <= 1'b0;
      busy    <= 1'b0;
      sym_stb <= 1'b0;
    end else begin
      acc     <= acc + fcw;
      sig     <= acc[PHASE_W-1] ^ cur_bit;
      busy    <= (state != S_IDLE);
      sym_stb <= (state != S_IDLE) && sym_end;
    end
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state   <= S_IDLE;
      sym_cnt <= '0;
      bit_idx <= 3'd7;
      pre_cnt <= '0;
      shreg   <= '0;
      cur_bit <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            shreg   <= data;
            sym_cnt <= '0;
            pre_cnt <= '0;
            cur_bit <= 1'b1;
            state   <= S_PRE;
          end
        end
        S_PRE: begin
          sym_cnt <= sym_end ? '0 : sym_cnt + CNT_W'(1);
          if (sym_end) begin
            if (pre_cnt == PRE_LAST) begin
              cur_bit <= shreg[7];
              bit_idx <= 3'd7;
              state   <= S_DATA;
            end else begin
              cur_bit <= ~cur_bit;
              pre_cnt <= pre_cnt + PRE_W'(1);
            end
          end
        end
        S_DATA: begin
          sym_cnt <= sym_end ? '0 : sym_cnt + CNT_W'(1);
          if (sym_end) begin
            if (bit_idx != 3'd0) begin
              bit_idx <= bit_idx - 3'd1;
              cur_bit <= shreg[bit_idx - 3'd1];
            end else if (valid) begin
              shreg   <= data;
              cur_bit <= data[7];
              bit_idx <= 3'd7;
            end else begin
              cur_bit <= 1'b0;
              state   <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_psk_modulator.sv
// Bench for dsp_psk_modulator: symbol-queue reference model compared every cycle,
// plus directed scenarios with hand-computed burst lengths and symbol sequences.
module tb_dsp_psk_modulator;

  localparam int PHASE_W = 13;
  localparam int SYM_LEN = 8;
  localparam int PRE     = 4;

  logic               clk    = 1'b0;
  logic               rst_in = 1'b1;
  logic [PHASE_W-1:0] fcw    = '0;
  logic [7:0]         data   = '0;
  logic               valid  = 1'b0;
  logic               ready;
  logic               sig;
  logic               busy;
  logic               sym_stb;

  dsp_psk_modulator #(
    .PHASE_W      (PHASE_W),
    .SYM_LEN      (SYM_LEN),
    .PREAMBLE_SYMS(PRE)
  ) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .fcw    (fcw),
    .data   (data),
    .valid  (valid),
    .ready  (ready),
    .sig    (sig),
    .busy   (busy),
    .sym_stb(sym_stb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue holding one entry per symbol still to be sent.
  logic [PHASE_W-1:0] m_acc = '0;
  bit                 m_q[$];
  int                 m_clk = 0;
  bit                 m_active;
  bit                 m_hs;
  logic               e_sig = 1'b0, e_busy = 1'b0, e_stb = 1'b0;

  function automatic bit m_ready();
    return (m_q.size() == 0) || (m_q.size() == 1 && m_clk == SYM_LEN - 1);
  endfunction

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) m_q.push_back(b[i]);
  endtask

  initial forever begin
    @(posedge clk);
    if (!rst_in) begin
      m_acc = '0;
      m_q.delete();
      m_clk = 0;
      e_sig = 1'b0; e_busy = 1'b0; e_stb = 1'b0;
    end else begin
      m_active = (m_q.size() > 0);
      m_hs     = valid && m_ready();
      e_sig    = m_acc[PHASE_W-1] ^ (m_active ? m_q[0] : 1'b0);
      e_busy   = m_active;
      e_stb    = m_active && (m_clk == SYM_LEN - 1);
      m_acc    = m_acc + fcw;
      if (m_active) begin
        if (m_clk == SYM_LEN - 1) begin
          void'(m_q.pop_front());
          m_clk = 0;
          if (m_hs) push_byte(data);
        end else begin
          m_clk++;
        end
      end else if (m_hs) begin
        for (int i = 0; i < PRE; i++) m_q.push_back((i % 2 == 0) ? 1'b1 : 1'b0);
        push_byte(data);
        m_clk = 0;
      end
    end
  end

  // Per-cycle compare plus burst monitors, sampled on the falling edge.
  int          busy_cnt = 0, stb_cnt = 0, bursts = 0;
  logic [31:0] sym_bits = '0;
  logic        busy_prev = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!rst_in) begin
      chk("rst_sig", sig, 0);
      chk("rst_ready", ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_stb", sym_stb, 0);
    end else begin
      chk("sig", sig, e_sig);
      chk("busy", busy, e_busy);
      chk("sym_stb", sym_stb, e_stb);
      chk("ready", ready, m_ready());
      if (busy) busy_cnt++;
      if (busy && !busy_prev) bursts++;
      if (sym_stb) begin
        stb_cnt++;
        sym_bits = {sym_bits[30:0], sig};
      end
    end
    busy_prev = busy;
  end

  task automatic clear_mon();
    busy_cnt = 0; stb_cnt = 0; bursts = 0; sym_bits = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_in = 1'b1;
    @(posedge clk); #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge, valid left high.
  task automatic handshake(input logic [7:0] b);
    int n;
    n = 0;
    data  = b;
    valid = 1'b1;
    @(negedge clk);
    while (!ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: actual=ready0 required=ready1 at %0t", $time);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!busy && n < 100) begin
      @(posedge clk); #1; n++;
    end
    while (busy && n < 5000) begin
      @(posedge clk); #1; n++;
    end
    if (busy || n >= 100 && n >= 5000) begin
      checks++; errors++;
      $display("FAIL wait_idle_timeout: actual=%0d cycles required=idle at %0t", n, $time);
    end
  endtask

  initial begin
    #1 rst_in = 1'b0;
    repeat (3) @(posedge clk);

    // Idle carrier: period 16, first rise on the 9th edge after release.
    fcw = 13'd512;
    @(negedge clk); #2 rst_in = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      if (k == 1)  chk("idle_c1", sig, 0);
      if (k == 8)  chk("idle_c8", sig, 0);
      if (k == 9)  chk("idle_c9", sig, 1);
      if (k == 16) chk("idle_c16", sig, 1);
      if (k == 17) chk("idle_c17", sig, 0);
    end

    // Single byte with a flat carrier.
    fcw = '0;
    do_reset();
    clear_mon();
    handshake(8'hA5);
    valid = 1'b0;
    wait_idle();
    chk("single_busy_cnt", busy_cnt, 96);
    chk("single_stb_cnt", stb_cnt, 12);
    chk("single_syms", {20'd0, sym_bits[11:0]}, 32'hAA5);
    chk("single_bursts", bursts, 1);
    chk("single_idle_sig", sig, 0);

    // Back-to-back bytes with valid held high.
    clear_mon();
    handshake(8'hFF);
    handshake(8'h00);
    valid = 1'b0;
    wait_idle();
    chk("b2b_busy_cnt", busy_cnt, 160);
    chk("b2b_stb_cnt", stb_cnt, 20);
    chk("b2b_syms", {12'd0, sym_bits[19:0]}, 32'hAFF00);
    chk("b2b_bursts", bursts, 1);

    // Underrun: second byte gets its own preamble.
    clear_mon();
    handshake(8'h81);
    valid = 1'b0;
    wait_idle();
    repeat (20) @(posedge clk);
    #1;
    handshake(8'h3C);
    valid = 1'b0;
    wait_idle();
    chk("under_busy_cnt", busy_cnt, 192);
    chk("under_stb_cnt", stb_cnt, 24);
    chk("under_syms", {8'd0, sym_bits[23:0]}, 32'hA81A3C);
    chk("under_bursts", bursts, 2);

    // Phase continuity with a running carrier across bursts.
    fcw = 13'd512;
    handshake(8'($urandom));
    handshake(8'($urandom));
    valid = 1'b0;
    wait_idle();
    handshake(8'($urandom));
    valid = 1'b0;
    wait_idle();

    // Reset mid-burst.
    handshake(8'h5A);
    valid = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk); #2 rst_in = 1'b0;
    #1;
    chk("async_sig", sig, 0);
    chk("async_ready", ready, 0);
    chk("async_busy", busy, 0);
    chk("async_stb", sym_stb, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_in = 1'b1;
    #1;
    chk("release_ready", ready, 1);
    @(posedge clk); #1;
    chk("post_ready", ready, 1);
    chk("post_busy", busy, 0);

    // Randomized traffic: data churns every cycle, valid and fcw vary.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      data  = 8'($urandom);
      valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) valid = 1'b0;
      if ($urandom_range(0, 31) == 0) fcw = PHASE_W'($urandom);
    end
    valid = 1'b0;
    repeat ((PRE + 16) * SYM_LEN + 4) @(posedge clk);
    #1;
    chk("final_busy", busy, 0);
    chk("final_ready", ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
